probe_trace_buffer: RTL and testbench
=====================================

# probe_trace_buffer

Pre/post-trigger trace buffer that captures a wide probe bus into on-chip RAM and streams the recorded window out as bytes over a valid/ready interface. It is the readout counterpart to the on-chip debug-probe capture path in the HDMI face pipeline. A small controller (UART bridge or soft CPU) arms it, and a design event triggers it. The controller then reads back the window oldest-first without vendor tooling.

## Interface
- DATA_W, 40: probe sample width in bits, 1..64.
- DEPTH, 1024: samples per capture window; power of two, ≥ 4.
- PRE_TRIG, 256: samples kept before the trigger sample; 0 ≤ PRE_TRIG ≤ DEPTH-1.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- probe_data  in  DATA_W  sample to record.
- probe_valid  in  1  qualifies probe_data; one sample is written per cycle where it is high.
- arm  in  1  one-cycle start pulse; honoured only in IDLE.
- abort  in  1  returns to IDLE from any state next cycle; highest priority after reset.
- trig  in  1  trigger; honoured only in ARMED on a cycle with probe_valid=1.
- out_data  out  8  readout byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.
- state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, DUMP=4.

## Operation
- Storage is a DEPTH×DATA_W single-clock RAM, written at wptr and read synchronously with 1-cycle latency. wptr is log2(DEPTH) bits and wraps modulo DEPTH.
- IDLE: an arm pulse clears wptr and the sample counter cnt, then moves to PRE. If PRE_TRIG=0, arm goes straight to ARMED.
- PRE: each valid sample is written and cnt increments. When cnt reaches PRE_TRIG the state moves to ARMED. trig is ignored in PRE.
- ARMED: valid samples keep writing and the ring wraps freely. The trigger sample is the sample written on a cycle with trig=1 and probe_valid=1. That cycle latches tptr=wptr and sets cnt=0, then the state moves to POST. If DEPTH-PRE_TRIG-1 = 0, the state goes directly to DUMP.
- POST: valid samples are written until DEPTH-PRE_TRIG-1 more have been stored, then the state moves to DUMP. trig is ignored.
- DUMP:
  - Read start address is (tptr − PRE_TRIG) mod DEPTH.
  - Exactly DEPTH samples are emitted, oldest first, with the address wrapping modulo DEPTH.
  - Each sample is sent as NB = ceil(DATA_W/8) bytes, least-significant byte first. Unused top bits of the last byte are 0.
  - probe_valid is ignored and no writes occur.
- After the last byte handshake: done pulses for 1 cycle, then IDLE.
- Sample index PRE_TRIG in the dump is always the trigger sample.
- abort: output goes to IDLE next cycle with out_valid=0, in any state. RAM contents are unspecified afterwards.
- arm outside IDLE is ignored. If arm and abort arrive in the same cycle, abort wins.

## Timing
- Reset values: out_data=0, out_valid=0, done=0, busy=0, state=IDLE. Internal pointers and counters are 0.
- A write lands in the RAM on the clock edge that samples probe_valid=1. The state transition happens on that same edge.
- First out_valid rises no later than 3 cycles after entering DUMP.
- Handshake rules:
  - A byte transfers on any edge where out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data is held stable and out_valid stays high.
  - out_valid never depends combinationally on out_ready.
- Throughput is sustained at 1 byte/cycle with out_ready held high (read prefetch/skid required). Total DUMP bytes = DEPTH×NB.
- done is asserted on the cycle after the final transfer, together with state=IDLE and busy=0.
- Reset asserted mid-capture or mid-dump clears all outputs asynchronously. After deassertion the block behaves as freshly reset.

## Test plan
Common setup unless noted: DEPTH=16, PRE_TRIG=4, DATA_W=40; probe_data is a counter starting at 0 with probe_valid=1.

- Basic capture:
  - Stimulus: arm at counter 0, trig at value 20, out_ready=1.
  - Required: 80 bytes, samples 16..31. First 5 bytes are 0x10,0,0,0,0 and bytes 20..24 are 0x14,0,0,0,0. done pulses once.
- Pre-fill guard:
  - Stimulus: trig asserted at values 1..3 during PRE, then at 30.
  - Required: the early triggers are ignored. Dump contains samples 26..41.
- Gapped probe_valid and backpressure:
  - Stimulus: probe_valid toggles every other cycle, out_ready is random at 30%.
  - Required: dump matches the reference model exactly. out_data stays stable while stalled. No byte is dropped or duplicated.
- PRE_TRIG=0 and PRE_TRIG=15:
  - Stimulus: trig at value 5 in each configuration.
  - Required: PRE_TRIG=0 dumps samples 5..20. PRE_TRIG=15 dumps samples −10..5 mod wrap, with the trigger sample as the last sample dumped.
- Abort and reset:
  - Stimulus: abort in POST, then rst_n pulsed low mid-DUMP.
  - Required: each returns to state=0 with out_valid=0 and done=0. A subsequent arm/trig capture is correct.
- Wide sample:
  - Stimulus: DATA_W=12, sample 0xABC.
  - Required: bytes are 0xBC then 0x0A, with NB=2.

Source files
------------

// File: rtl/probe_trace_buffer.sv
// Pre/post-trigger trace buffer: records a probe bus into a ring RAM around a trigger
// event, then streams the captured window oldest-first as LSB-first bytes over valid/ready.
module probe_trace_buffer #(
  parameter int DATA_W   = 40,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_data,
  input  logic              probe_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  localparam int AW     = $clog2(DEPTH);
  localparam int NB     = (DATA_W + 7) / 8;
  localparam int SH_W   = NB * 8;
  localparam int BW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [AW:0]   PRE_CNT   = (AW+1)'(PRE_TRIG);
  localparam logic [AW:0]   POST_CNT  = (AW+1)'(POST_N);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST_B    = BW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DUMP  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Capture side
  logic [AW-1:0] wptr, tptr, cnt;
  logic [AW:0]   cnt_inc;
  logic          capturing, we, trig_hit;

  // Storage and readout side
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_vld;
  logic [AW:0]       rd_idx;
  logic [AW-1:0]     rd_addr;
  logic              fifo_wr, fifo_rd;
  logic [1:0]        fifo_cnt;
  logic [SH_W-1:0]   sh;
  logic [BW-1:0]     bidx;
  logic              fire, last_byte, need_load, take_fifo, take_rd, push, issue, final_xfer;
  logic [2:0]        occ, credit;

  assign capturing = state_q inside {PRE, ARMED, POST};
  assign we        = capturing && probe_valid;
  assign trig_hit  = (state_q == ARMED) && probe_valid && trig;
  assign cnt_inc   = {1'b0, cnt} + (AW+1)'(1);

  assign out_data = sh[7:0];
  assign busy     = (state_q != IDLE);
  assign state    = state_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          if (PRE_TRIG == 0) state_d = ARMED;
          else               state_d = PRE;
        end
      end
      PRE:   if (probe_valid && cnt_inc == PRE_CNT) state_d = ARMED;
      ARMED: begin
        if (trig_hit) begin
          if (POST_N == 0) state_d = DUMP;
          else             state_d = POST;
        end
      end
      POST:  if (probe_valid && cnt_inc == POST_CNT) state_d = DUMP;
      DUMP:  if (final_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // cnt counts pre-fill samples, then is reused to count post-trigger samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      tptr <= '0;
      cnt  <= '0;
    end else if (state_q == IDLE) begin
      if (arm) begin
        wptr <= '0;
        cnt  <= '0;
      end
    end else if (we) begin
      wptr <= wptr + AW'(1);
      if (trig_hit) begin
        tptr <= wptr;
        cnt  <= '0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // NOTE: RAM and skid storage carry no reset; only the control flags that qualify them do.
  always_ff @(posedge clk) begin
    if (we)    mem[wptr] <= probe_data;
    if (issue) rdata     <= mem[rd_addr];
    if (push)  fifo_mem[fifo_wr] <= rdata;
  end

  // Readout: RAM read (1 cycle) -> 2-entry skid -> byte serializer. Reads are issued only
  // when the skid can absorb them, counting the one in flight.
  always_comb begin
    rd_addr    = tptr - PRE_OFF + rd_idx[AW-1:0];
    fire       = out_valid && out_ready;
    last_byte  = (bidx == LAST_B);
    need_load  = !out_valid || (fire && last_byte);
    take_fifo  = need_load && (fifo_cnt != 2'd0);
    take_rd    = need_load && (fifo_cnt == 2'd0) && rd_vld;
    push       = rd_vld && !take_rd;
    occ        = {1'b0, fifo_cnt} + {2'b00, rd_vld};
    credit     = 3'd1 + {2'b00, (take_fifo || take_rd)};
    issue      = (state_q == DUMP) && !abort && (rd_idx != DEPTH_CNT) && (occ <= credit);
    final_xfer = (state_q == DUMP) && fire && last_byte && (fifo_cnt == 2'd0) && !rd_vld
                 && (rd_idx == DEPTH_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= 1'b0;
      rd_idx    <= '0;
      fifo_wr   <= 1'b0;
      fifo_rd   <= 1'b0;
      fifo_cnt  <= 2'd0;
      sh        <= '0;
      bidx      <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= final_xfer && !abort;
      if (state_q != DUMP || abort) begin
        rd_vld    <= 1'b0;
        rd_idx    <= '0;
        fifo_wr   <= 1'b0;
        fifo_rd   <= 1'b0;
        fifo_cnt  <= 2'd0;
        bidx      <= '0;
        out_valid <= 1'b0;
      end else begin
        rd_vld <= issue;
        if (issue)     rd_idx  <= rd_idx + (AW+1)'(1);
        if (push)      fifo_wr <= ~fifo_wr;
        if (take_fifo) fifo_rd <= ~fifo_rd;
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, take_fifo};
        if (take_fifo) begin
          sh        <= SH_W'(fifo_mem[fifo_rd]);
          bidx      <= '0;
          out_valid <= 1'b1;
        end else if (take_rd) begin
          sh        <= SH_W'(rdata);
          bidx      <= '0;
          out_valid <= 1'b1;
        end else if (need_load) begin
          out_valid <= 1'b0;
        end else if (fire) begin
          sh   <= sh >> 8;
          bidx <= bidx + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_probe_trace_buffer.sv
// Directed bench for probe_trace_buffer: four configurations share stimulus, one is observed
// per scenario; a queue of written samples gives the expected dump window.
module tb_probe_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [39:0] probe_data = '0;
  logic        probe_valid = 1'b0, arm = 1'b0, abort = 1'b0, trig = 1'b0, out_ready = 1'b0;

  logic [7:0] od [4];
  logic       ov [4];
  logic       bz [4];
  logic       dn [4];
  logic [2:0] st [4];

  always #5 clk = ~clk;

  probe_trace_buffer #(.DATA_W(40), .DEPTH(DEPTH), .PRE_TRIG(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .probe_data(probe_data), .probe_valid(probe_valid),
    .arm(arm), .abort(abort), .trig(trig), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .busy(bz[0]), .done(dn[0]), .state(st[0]));
  probe_trace_buffer #(.DATA_W(40), .DEPTH(DEPTH), .PRE_TRIG(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .probe_data(probe_data), .probe_valid(probe_valid),
    .arm(arm), .abort(abort), .trig(trig), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .busy(bz[1]), .done(dn[1]), .state(st[1]));
  probe_trace_buffer #(.DATA_W(40), .DEPTH(DEPTH), .PRE_TRIG(15)) u_p15 (
    .clk(clk), .rst_n(rst_n), .probe_data(probe_data), .probe_valid(probe_valid),
    .arm(arm), .abort(abort), .trig(trig), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .busy(bz[2]), .done(dn[2]), .state(st[2]));
  probe_trace_buffer #(.DATA_W(12), .DEPTH(DEPTH), .PRE_TRIG(4)) u_w12 (
    .clk(clk), .rst_n(rst_n), .probe_data(probe_data[11:0]), .probe_valid(probe_valid),
    .arm(arm), .abort(abort), .trig(trig), .out_data(od[3]), .out_valid(ov[3]),
    .out_ready(out_ready), .busy(bz[3]), .done(dn[3]), .state(st[3]));

  logic [1:0] sel = 2'd0;
  logic [7:0] c_data;
  logic       c_valid, c_busy, c_done;
  logic [2:0] c_state;

  always_comb begin
    c_data  = od[sel];
    c_valid = ov[sel];
    c_busy  = bz[sel];
    c_done  = dn[sel];
    c_state = st[sel];
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         done_cnt, first_cyc, last_cyc, dump_cyc, end_cyc;
  logic [2:0] dump_state, last_state;
  bit         timed_out;

  // One capture+dump run on instance s; the model records every written sample.
  task automatic run_capture(input logic [1:0] s, input logic [39:0] start, input logic [39:0] trig_val,
                             input bit gapped, input bit prefill, input int ready_pct,
                             input int abort_cyc, input int rst_bytes);
    int          pre, post, nb, w, trig_idx;
    logic [63:0] mask;
    logic [63:0] wr_q [$];
    logic [39:0] ctr;
    logic [7:0]  prev_data;
    bit          v, prev_stall, stop;
    sel = s;
    w    = (s == 2'd3) ? 12 : 40;
    pre  = (s == 2'd1) ? 0 : (s == 2'd2) ? 15 : 4;
    post = DEPTH - pre - 1;
    nb   = (w + 7) / 8;
    mask = (64'd1 << w) - 64'd1;
    got_q.delete(); exp_q.delete();
    done_cnt = 0; first_cyc = -1; last_cyc = -1; dump_cyc = -1; end_cyc = -1;
    trig_idx = -1; dump_state = '0; last_state = '0; timed_out = 1'b0;
    prev_stall = 1'b0; prev_data = '0; stop = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1; arm = 1'b0; trig = 1'b0; probe_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
      ctr = start + 40'(cyc);
      v = gapped ? (cyc % 2 == 0) : 1'b1;
      probe_data  = ctr;
      probe_valid = v;
      arm   = (cyc == 0);
      abort = (cyc == abort_cyc);
      trig  = v && ((ctr == trig_val) || (prefill && cyc >= 1 && cyc <= 3));
      out_ready = ($urandom_range(0, 99) < 32'(ready_pct));
      if (cyc >= 1 && v) begin
        if (trig_idx < 0 && ctr == trig_val) trig_idx = wr_q.size();
        wr_q.push_back(64'(ctr) & mask);
        if (trig_idx >= 0 && dump_cyc < 0 && wr_q.size() == trig_idx + post + 1) dump_cyc = cyc + 1;
      end
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!c_valid || c_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got valid=%0b data=%02h exp valid=1 data=%02h",
                   cyc, c_valid, c_data, prev_data);
        end
      end
      prev_stall = c_valid && !out_ready;
      prev_data  = c_data;
      last_state = c_state;
      if (cyc == dump_cyc) dump_state = c_state;
      if (c_done) begin
        done_cnt++;
        checks++;
        if (c_state !== 3'd0 || c_busy !== 1'b0) begin
          failures++;
          $display("FAIL done_with_idle got state=%0d busy=%0b exp state=0 busy=0", c_state, c_busy);
        end
        if (end_cyc < 0) end_cyc = cyc;
      end
      if (c_valid && out_ready) begin
        got_q.push_back(c_data);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (rst_bytes >= 0 && got_q.size() == rst_bytes) begin
          #1 rst_n = 1'b0;
          stop = 1'b1;
        end
      end
      if (abort_cyc >= 0 && cyc == abort_cyc) stop = 1'b1;
      if (end_cyc >= 0 && cyc == end_cyc + 3) stop = 1'b1;
      if (!stop) begin
        @(posedge clk); #1;
      end
    end
    if (!stop) timed_out = 1'b1;
    if (trig_idx >= pre) begin
      for (int i = trig_idx - pre; i <= trig_idx + post && i < wr_q.size(); i++)
        for (int b = 0; b < nb; b++) exp_q.push_back(8'(wr_q[i] >> (8 * b)));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({od[i], ov[i], dn[i], bz[i], st[i]} !== 14'd0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got=%04h exp=0000", i, {od[i], ov[i], dn[i], bz[i], st[i]});
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int bad, at;
    logic [79:0] hand;
    run_capture(2'd0, 40'd0, 40'd20, 1'b0, 1'b0, 100, -1, -1);
    checks++;
    if (timed_out || done_cnt != 1) begin
      failures++; $display("FAIL basic_done got=%0d timeout=%0b exp=1", done_cnt, timed_out);
    end
    checks++;
    if (got_q.size() != 80) begin failures++; $display("FAIL basic_len got=%0d exp=80", got_q.size()); end
    hand = 'x;
    if (got_q.size() >= 25) hand = {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4],
                                    got_q[20], got_q[21], got_q[22], got_q[23], got_q[24]};
    checks++;
    if (hand !== 80'h10_00_00_00_00_14_00_00_00_00) begin
      failures++; $display("FAIL basic_bytes got=%020h exp=10000000001400000000", hand);
    end
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      failures++; $display("FAIL basic_model first_bad=%0d bad=%0d got_len=%0d exp_len=%0d", at, bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (dump_state !== 3'd4) begin failures++; $display("FAIL basic_dump_state got=%0d exp=4", dump_state); end
    checks++;
    if (first_cyc < dump_cyc || first_cyc > dump_cyc + 3 || last_cyc - first_cyc != 79) begin
      failures++;
      $display("FAIL basic_timing got first=%0d span=%0d exp first in [%0d..%0d] span=79",
               first_cyc, last_cyc - first_cyc, dump_cyc, dump_cyc + 3);
    end
  endtask

  task automatic test_prefill_guard();
    int bad, at;
    run_capture(2'd0, 40'd0, 40'd30, 1'b0, 1'b1, 100, -1, -1);
    checks++;
    if (got_q.size() != 80 || got_q[0] !== 8'h1A || got_q[75] !== 8'h29) begin
      failures++; $display("FAIL prefill_ends got_len=%0d exp first=1a last=29", got_q.size());
    end
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size() || exp_q.size() == 0 || timed_out) begin
      failures++; $display("FAIL prefill_model first_bad=%0d bad=%0d got_len=%0d exp_len=%0d", at, bad, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_gapped_backpressure();
    int bad, at;
    run_capture(2'd0, 40'd0, 40'd40, 1'b1, 1'b0, 30, -1, -1);
    checks++;
    if (timed_out || done_cnt != 1 || got_q.size() != 80 || got_q[0] !== 8'h20) begin
      failures++; $display("FAIL gapped_shape got_len=%0d done=%0d exp_len=80 done=1 first=20", got_q.size(), done_cnt);
    end
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      failures++; $display("FAIL gapped_model first_bad=%0d bad=%0d got_len=%0d exp_len=%0d", at, bad, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_pre_trig_edges();
    int bad, at;
    run_capture(2'd1, 40'd0, 40'd5, 1'b0, 1'b0, 100, -1, -1);
    checks++;
    if (timed_out || got_q.size() != 80 || got_q[0] !== 8'h05 || got_q[75] !== 8'h14) begin
      failures++; $display("FAIL pre0_ends got_len=%0d exp_len=80 first=05 last=14", got_q.size());
    end
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      failures++; $display("FAIL pre0_model first_bad=%0d bad=%0d", at, bad);
    end
    run_capture(2'd2, 40'hFF_FFFF_FFEC, 40'd5, 1'b0, 1'b0, 100, -1, -1);
    checks++;
    if (timed_out || got_q.size() != 80 || got_q[0] !== 8'hF6 || got_q[4] !== 8'hFF || got_q[75] !== 8'h05) begin
      failures++; $display("FAIL pre15_ends got_len=%0d exp_len=80 first=f6 byte4=ff last=05", got_q.size());
    end
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      failures++; $display("FAIL pre15_model first_bad=%0d bad=%0d", at, bad);
    end
  endtask

  task automatic test_abort();
    int bad, at;
    run_capture(2'd0, 40'd0, 40'd20, 1'b0, 1'b0, 100, 25, -1);
    checks++;
    if (last_state !== 3'd3) begin failures++; $display("FAIL abort_in_post got state=%0d exp=3", last_state); end
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (c_state !== 3'd0 || c_valid !== 1'b0 || c_done !== 1'b0 || c_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got state=%0d valid=%0b done=%0b busy=%0b exp 0 0 0 0", c_state, c_valid, c_done, c_busy);
    end
    run_capture(2'd0, 40'd100, 40'd120, 1'b0, 1'b0, 100, -1, -1);
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != 80 || exp_q.size() != 80 || got_q[0] !== 8'h74 || done_cnt != 1) begin
      failures++; $display("FAIL abort_recapture first_bad=%0d bad=%0d got_len=%0d exp_len=80", at, bad, got_q.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    int bad, at;
    run_capture(2'd0, 40'd0, 40'd20, 1'b0, 1'b0, 100, -1, 10);
    #1;
    checks++;
    if (got_q.size() != 10 || c_state !== 3'd0 || c_valid !== 1'b0 || c_done !== 1'b0 || c_busy !== 1'b0 || c_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_dump got bytes=%0d state=%0d valid=%0b done=%0b busy=%0b data=%02h exp 10 0 0 0 0 00",
               got_q.size(), c_state, c_valid, c_done, c_busy, c_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    run_capture(2'd0, 40'd50, 40'd70, 1'b0, 1'b0, 100, -1, -1);
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != 80 || exp_q.size() != 80 || got_q[0] !== 8'h42 || done_cnt != 1) begin
      failures++; $display("FAIL reset_recapture first_bad=%0d bad=%0d got_len=%0d exp_len=80", at, bad, got_q.size());
    end
  endtask

  task automatic test_wide_sample();
    int bad, at;
    run_capture(2'd3, 40'hAB0, 40'hABC, 1'b0, 1'b0, 100, -1, -1);
    checks++;
    if (timed_out || got_q.size() != 32 || got_q[8] !== 8'hBC || got_q[9] !== 8'h0A) begin
      failures++; $display("FAIL wide_bytes got_len=%0d exp_len=32 byte8=bc byte9=0a", got_q.size());
    end
    bad = 0; at = -1;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; if (at < 0) at = i; end
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      failures++; $display("FAIL wide_model first_bad=%0d bad=%0d", at, bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefill_guard();
    test_gapped_backpressure();
    test_pre_trig_edges();
    test_abort();
    test_reset_mid_dump();
    test_wide_sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
